// File: rtl/mem1rw_req_ctrl.sv
// Request front-end for the Memory1RW single-port SRAM: credit-gated request acceptance,
// one memory op per cycle, and a response FIFO that captures 1-cycle-latency read data.
module mem1rw_req_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 64,
  parameter int RESP_DEPTH = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers on a rising edge where resp_valid && resp_ready. Neither
  // valid may depend on its ready, and req_ready never depends on req_* or resp_ready.

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(RESP_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RESP_DEPTH - 1);

  logic [CNT_W-1:0]  count_q, count_d;
  logic              rd_inflight_q, rd_inflight_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] storage_q [RESP_DEPTH];

  logic [CNT_W:0] credits_used;
  logic           acc;
  logic           push;
  logic           pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // A read in flight already owns a FIFO slot, so it counts against the credit.
  assign credits_used = {1'b0, count_q} + {{CNT_W{1'b0}}, rd_inflight_q};
  assign req_ready    = reset && (credits_used < {1'b0, FULL});
  assign acc          = req_valid && req_ready;

  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;
  assign mem_we    = acc && req_write;

  assign push       = rd_inflight_q;
  assign resp_valid = (count_q != '0);
  assign pop        = resp_valid && resp_ready;
  assign resp_rdata = storage_q[rd_ptr_q];

  always_comb begin
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    rd_inflight_d = acc && !req_write;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q       <= '0;
      rd_inflight_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) storage_q[i] <= '0;
    end else begin
      count_q       <= count_d;
      rd_inflight_q <= rd_inflight_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      if (push) storage_q[wr_ptr_q] <= mem_rdata;
    end
  end

  overflow_chk: assert property (@(posedge clock) disable iff (!reset)
    !(push && (count_q == FULL)));

endmodule
